// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 decode constants, D-register record and the
//               nop bubble loaded on reset or bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [2:0]  stat;
    } dreg_t;

    localparam dreg_t NOP_BUBBLE = '{
        icode: INOP,
        ifun:  4'h0,
        rA:    RNONE,
        rB:    RNONE,
        valC:  64'h0,
        valP:  64'h0,
        stat:  SAOK
    };

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : Y86-64 program register file, two combinational reads and two
//               synchronous writes (M port wins). Optional write-back bypass
//               on the read ports when DECODE_WB_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
    import y86_pkg::*;
#(
    parameter int          NREG      = 15,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_srcA,
    input  logic [3:0]  i_srcB,
    input  logic [3:0]  i_dstE,
    input  logic [63:0] i_valE,
    input  logic [3:0]  i_dstM,
    input  logic [63:0] i_valM,
    output logic [63:0] o_valA,
    output logic [63:0] o_valB
);

    logic [63:0] r_regs [NREG];
    logic [63:0] w_rawA;
    logic [63:0] w_rawB;

    // M is written after E so the nonblocking update from M takes effect last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            if (i_dstE != RNONE) begin
                r_regs[i_dstE] <= i_valE;
            end
            if (i_dstM != RNONE) begin
                r_regs[i_dstM] <= i_valM;
            end
        end
    end

    always_comb begin
        w_rawA = (i_srcA == RNONE) ? 64'h0 : r_regs[i_srcA];
        w_rawB = (i_srcB == RNONE) ? 64'h0 : r_regs[i_srcB];
    end

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        o_valA = w_rawA;
        if (i_srcA != RNONE && i_srcA == i_dstM) begin
            o_valA = i_valM;
        end else if (i_srcA != RNONE && i_srcA == i_dstE) begin
            o_valA = i_valE;
        end
        o_valB = w_rawB;
        if (i_srcB != RNONE && i_srcB == i_dstM) begin
            o_valB = i_valM;
        end else if (i_srcB != RNONE && i_srcB == i_dstE) begin
            o_valB = i_valE;
        end
    end
`else
    always_comb begin
        o_valA = w_rawA;
        o_valB = w_rawB;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/decode_regfile.sv
// ============================================================================
// Module      : decode_regfile
// Description : Y86-64 decode stage: D pipeline register, status derivation,
//               register-ID selection and operand read. Build macro
//               DECODE_WB_BYPASS_EN enables same-cycle write-back bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_regfile
    import y86_pkg::*;
#(
    parameter int          NREG      = 15,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_inst_valid,
    input  logic        f_imem_er,
    input  logic        f_hlt_er,
    input  logic        d_stall,
    input  logic        d_bubble,
    input  logic [3:0]  w_dstE,
    input  logic [3:0]  w_dstM,
    input  logic [63:0] w_valE,
    input  logic [63:0] w_valM,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [63:0] d_valC,
    output logic [63:0] d_valP,
    output logic [2:0]  d_stat,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB
);

    dreg_t       r_d;
    dreg_t       w_fetch;
    logic [63:0] w_rfA;
    logic [63:0] w_rfB;

    always_comb begin
        w_fetch.icode = f_icode;
        w_fetch.ifun  = f_ifun;
        w_fetch.rA    = f_rA;
        w_fetch.rB    = f_rB;
        w_fetch.valC  = f_valC;
        w_fetch.valP  = f_valP;
        if (f_imem_er) begin
            w_fetch.stat = SADR;
        end else if (!f_inst_valid) begin
            w_fetch.stat = SINS;
        end else if (f_hlt_er) begin
            w_fetch.stat = SHLT;
        end else begin
            w_fetch.stat = SAOK;
        end
    end

    // Stall outranks bubble so a held instruction is never squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= NOP_BUBBLE;
        end else if (d_stall) begin
            r_d <= r_d;
        end else if (d_bubble) begin
            r_d <= NOP_BUBBLE;
        end else begin
            r_d <= w_fetch;
        end
    end

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (r_d.icode)
            IRRMOVQ: begin d_srcA = r_d.rA; d_dstE = r_d.rB; end
            IIRMOVQ: begin d_dstE = r_d.rB; end
            IRMMOVQ: begin d_srcA = r_d.rA; d_srcB = r_d.rB; end
            IMRMOVQ: begin d_srcB = r_d.rB; d_dstM = r_d.rA; end
            IOPQ:    begin d_srcA = r_d.rA; d_srcB = r_d.rB; d_dstE = r_d.rB; end
            ICALL:   begin d_srcB = RRSP;   d_dstE = RRSP; end
            IRET:    begin d_srcA = RRSP;   d_srcB = RRSP; d_dstE = RRSP; end
            IPUSHQ:  begin d_srcA = r_d.rA; d_srcB = RRSP; d_dstE = RRSP; end
            IPOPQ:   begin d_srcA = RRSP;   d_srcB = RRSP; d_dstE = RRSP; d_dstM = r_d.rA; end
            default: ;
        endcase
    end

    regfile #(
        .NREG      (NREG),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_srcA (d_srcA),
        .i_srcB (d_srcB),
        .i_dstE (w_dstE),
        .i_valE (w_valE),
        .i_dstM (w_dstM),
        .i_valM (w_valM),
        .o_valA (w_rfA),
        .o_valB (w_rfB)
    );

    always_comb begin
        d_icode = r_d.icode;
        d_ifun  = r_d.ifun;
        d_valC  = r_d.valC;
        d_valP  = r_d.valP;
        d_stat  = r_d.stat;
        d_valA  = (r_d.icode == IJXX || r_d.icode == ICALL) ? r_d.valP : w_rfA;
        d_valB  = w_rfB;
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_regfile.sv
// ============================================================================
// Module      : tb_decode_regfile
// Description : Self-checking bench for decode_regfile against a behavioural
//               model of the D register and register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_inst_valid, f_imem_er, f_hlt_er;
    logic        d_stall, d_bubble;
    logic [3:0]  w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  d_icode, d_ifun;
    logic [63:0] d_valC, d_valP;
    logic [2:0]  d_stat;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [3:0]  m_icode, m_ifun, m_rA, m_rB;
    logic [63:0] m_valC, m_valP;
    logic [2:0]  m_stat;
    logic [63:0] m_rf [0:14];

    decode_regfile dut (
        .clk(clk), .rst(rst),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .f_inst_valid(f_inst_valid), .f_imem_er(f_imem_er), .f_hlt_er(f_hlt_er),
        .d_stall(d_stall), .d_bubble(d_bubble),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valP(d_valP),
        .d_stat(d_stat), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB)
    );

    always #5 clk = ~clk;

    // Membership masks: bit k set means icode k uses that source.
    function automatic logic [3:0] e_pick(input logic [15:0] reg_mask, input logic [15:0] rsp_mask,
                                          input logic [3:0] r);
        if (reg_mask[m_icode]) return r;
        if (rsp_mask[m_icode]) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] e_srcA(); return e_pick(16'h0454, 16'h0A00, m_rA); endfunction
    function automatic logic [3:0] e_srcB(); return e_pick(16'h0070, 16'h0F00, m_rB); endfunction
    function automatic logic [3:0] e_dstE(); return e_pick(16'h004C, 16'h0F00, m_rB); endfunction
    function automatic logic [3:0] e_dstM(); return e_pick(16'h0820, 16'h0000, m_rA); endfunction

    function automatic logic [63:0] e_read(input logic [3:0] id);
        logic [63:0] v;
        if (id == 4'hF) return 64'h0;
        v = m_rf[id];
`ifdef DECODE_WB_BYPASS_EN
        if (w_dstE == id) v = w_valE;
        if (w_dstM == id) v = w_valM;
`endif
        return v;
    endfunction

    function automatic logic [63:0] e_valA();
        if (m_icode == 4'h7 || m_icode == 4'h8) return m_valP;
        return e_read(e_srcA());
    endfunction

    task automatic m_nop();
        m_icode = 4'h1; m_ifun = 4'h0; m_rA = 4'hF; m_rB = 4'hF;
        m_valC = 64'h0; m_valP = 64'h0; m_stat = 3'd1;
    endtask

    // One clock: model follows the edge using the inputs held across it.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_nop();
            for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
        end else begin
            if (!d_stall) begin
                if (d_bubble) m_nop();
                else begin
                    m_icode = f_icode; m_ifun = f_ifun; m_rA = f_rA; m_rB = f_rB;
                    m_valC = f_valC; m_valP = f_valP;
                    m_stat = f_imem_er ? 3'd3 : (!f_inst_valid ? 3'd4 : (f_hlt_er ? 3'd2 : 3'd1));
                end
            end
            if (w_dstE != 4'hF) m_rf[w_dstE] = w_valE;
            if (w_dstM != 4'hF) m_rf[w_dstM] = w_valM;
        end
        #1;
    endtask

    task automatic idle_inputs();
        f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF;
        f_valC = 64'h0; f_valP = 64'h0;
        f_inst_valid = 1'b1; f_imem_er = 1'b0; f_hlt_er = 1'b0;
        d_stall = 1'b0; d_bubble = 1'b0;
        w_dstE = 4'hF; w_dstM = 4'hF; w_valE = 64'h0; w_valM = 64'h0;
    endtask

    task automatic load(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp);
        f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    task automatic test_reset();
        idle_inputs();
        load(4'h6, 4'h2, 4'h3, 64'hDEAD, 64'hBEEF);
        w_dstE = 4'h2; w_valE = 64'h1234;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_cmp++; if (d_icode !== 4'h1) begin n_err++; $display("FAIL reset_icode got %h exp 1", d_icode); end
        n_cmp++; if (d_stat !== 3'd1) begin n_err++; $display("FAIL reset_stat got %0d exp 1", d_stat); end
        n_cmp++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin
            n_err++; $display("FAIL reset_ids got %h exp ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
        n_cmp++; if ({d_valA, d_valB, d_valC, d_valP} !== 256'h0) begin
            n_err++; $display("FAIL reset_vals got %h %h %h %h exp 0", d_valA, d_valB, d_valC, d_valP); end
        for (int i = 0; i < 15; i++) begin
            load(4'h6, 4'(i), 4'(i), 64'h0, 64'h0);
            cycle();
            n_cmp++; if (d_valA !== 64'h0 || d_valB !== 64'h0) begin
                n_err++; $display("FAIL reset_reg%0d got %h/%h exp 0", i, d_valA, d_valB); end
        end
    endtask

    task automatic test_opq();
        idle_inputs();
        w_dstE = 4'h3; w_valE = 64'h55;
        cycle();
        idle_inputs();
        load(4'h6, 4'h3, 4'h3, 64'h0, 64'h0);
        cycle();
        n_cmp++; if (d_valA !== 64'h55 || d_valB !== 64'h55) begin
            n_err++; $display("FAIL opq_vals got %h/%h exp 55/55", d_valA, d_valB); end
        n_cmp++; if (d_dstE !== 4'h3) begin n_err++; $display("FAIL opq_dstE got %h exp 3", d_dstE); end
    endtask

    task automatic test_dual_write();
        logic [63:0] old_rsp;
        idle_inputs();
        w_dstE = 4'h4; w_valE = 64'h77;
        load(4'hB, 4'h2, 4'hF, 64'h0, 64'h0);
        cycle();
        idle_inputs();
        old_rsp = 64'h77;
        w_dstE = 4'h4; w_valE = 64'h10; w_dstM = 4'h4; w_valM = 64'h20;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        n_cmp++; if (d_valA !== 64'h20) begin n_err++; $display("FAIL dual_bypass got %h exp 20", d_valA); end
`else
        n_cmp++; if (d_valA !== old_rsp) begin n_err++; $display("FAIL dual_nobypass got %h exp %h", d_valA, old_rsp); end
`endif
        n_cmp++; if (d_dstM !== 4'h2 || d_dstE !== 4'h4) begin
            n_err++; $display("FAIL popq_dst got %h/%h exp 2/4", d_dstM, d_dstE); end
        f_icode = 4'hB; f_rA = 4'h2;
        cycle();
        idle_inputs();
        #1;
        n_cmp++; if (d_valA !== 64'h20 || d_valB !== 64'h20) begin
            n_err++; $display("FAIL dual_mwins got %h/%h exp 20/20", d_valA, d_valB); end
    endtask

    task automatic test_call();
        idle_inputs();
        load(4'h8, 4'hF, 4'hF, 64'h400, 64'h109);
        cycle();
        n_cmp++; if (d_valA !== 64'h109) begin n_err++; $display("FAIL call_valA got %h exp 109", d_valA); end
        n_cmp++; if (d_srcB !== 4'h4 || d_dstE !== 4'h4 || d_dstM !== 4'hF) begin
            n_err++; $display("FAIL call_ids got %h/%h/%h exp 4/4/f", d_srcB, d_dstE, d_dstM); end
    endtask

    task automatic test_stall_bubble();
        idle_inputs();
        load(4'h2, 4'h1, 4'h5, 64'hAAAA, 64'h3C);
        f_ifun = 4'h3;
        cycle();
        d_stall = 1'b1; d_bubble = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load(4'($urandom_range(0, 11)), 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)),
                 {$urandom, $urandom}, {$urandom, $urandom});
            f_inst_valid = 1'b0;
            cycle();
            n_cmp++; if ({d_icode, d_ifun, d_srcA, d_dstE, d_stat} !== {4'h2, 4'h3, 4'h1, 4'h5, 3'd1} ||
                         d_valC !== 64'hAAAA || d_valP !== 64'h3C) begin
                n_err++; $display("FAIL stall_hold%0d got %h %h %h %h %0d exp 2 3 1 5 1", k, d_icode, d_ifun,
                                  d_srcA, d_dstE, d_stat); end
        end
        d_stall = 1'b0;
        cycle();
        n_cmp++; if (d_icode !== 4'h1 || d_srcA !== 4'hF || d_dstE !== 4'hF || d_stat !== 3'd1 || d_valC !== 64'h0) begin
            n_err++; $display("FAIL bubble_nop got %h %h %h %0d exp 1 f f 1", d_icode, d_srcA, d_dstE, d_stat); end
    endtask

    task automatic test_stat();
        idle_inputs();
        f_imem_er = 1'b1; f_inst_valid = 1'b0; f_hlt_er = 1'b1;
        cycle();
        n_cmp++; if (d_stat !== 3'd3) begin n_err++; $display("FAIL stat_adr got %0d exp 3", d_stat); end
        f_imem_er = 1'b0;
        cycle();
        n_cmp++; if (d_stat !== 3'd4) begin n_err++; $display("FAIL stat_ins got %0d exp 4", d_stat); end
        f_inst_valid = 1'b1;
        cycle();
        n_cmp++; if (d_stat !== 3'd2) begin n_err++; $display("FAIL stat_hlt got %0d exp 2", d_stat); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            f_icode = 4'($urandom); f_ifun = 4'($urandom);
            f_rA = 4'($urandom); f_rB = 4'($urandom);
            f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
            f_inst_valid = ($urandom_range(0, 7) != 0);
            f_imem_er = ($urandom_range(0, 9) == 0);
            f_hlt_er = ($urandom_range(0, 9) == 0);
            d_stall = ($urandom_range(0, 5) == 0);
            d_bubble = ($urandom_range(0, 5) == 0);
            w_dstE = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            w_dstM = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            w_valE = {$urandom, $urandom}; w_valM = {$urandom, $urandom};
            #1;
            n_cmp++; if (d_icode !== m_icode || d_ifun !== m_ifun || d_stat !== m_stat) begin
                n_err++; $display("FAIL rnd_fields n=%0d got %h %h %0d exp %h %h %0d", n, d_icode, d_ifun, d_stat,
                                  m_icode, m_ifun, m_stat); end
            n_cmp++; if (d_valC !== m_valC || d_valP !== m_valP) begin
                n_err++; $display("FAIL rnd_valCP n=%0d got %h %h exp %h %h", n, d_valC, d_valP, m_valC, m_valP); end
            n_cmp++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== {e_srcA(), e_srcB(), e_dstE(), e_dstM()}) begin
                n_err++; $display("FAIL rnd_ids n=%0d got %h exp %h", n, {d_srcA, d_srcB, d_dstE, d_dstM},
                                  {e_srcA(), e_srcB(), e_dstE(), e_dstM()}); end
            n_cmp++; if (d_valA !== e_valA()) begin
                n_err++; $display("FAIL rnd_valA n=%0d got %h exp %h", n, d_valA, e_valA()); end
            n_cmp++; if (d_valB !== e_read(e_srcB())) begin
                n_err++; $display("FAIL rnd_valB n=%0d got %h exp %h", n, d_valB, e_read(e_srcB())); end
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_nop();
        for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
        test_reset();
        test_opq();
        test_dual_write();
        test_call();
        test_stall_bubble();
        test_stat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
